imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader_run_timer.sv | 41 ++++
 rtl/imem_loader.sv | 173 +++++++++++++++++
 tb/tb_imem_loader.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and parameter defaults for the instruction-memory loader.
// The state encoding is common to the loader, its interface and the bench.
package loader_pkg;

   localparam int D_DEF    = 10;
   localparam int TO_W_DEF = 16;

   typedef enum logic [2:0] {
      LEN_LO = 3'd0,
      LEN_HI = 3'd1,
      INS_LO = 3'd2,
      INS_HI = 3'd3,
      RUN    = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, instruction-memory write port and core control/status.
// master = host/core side, slave = loader.
interface imem_loader_if import loader_pkg::*; #(
   parameter int D    = D_DEF,
   parameter int TO_W = TO_W_DEF
);
   logic            s_valid;
   logic [7:0]      s_data;
   logic            s_ready;
   logic            im_wr_en;
   logic [D-1:0]    im_addr;
   logic [8:0]      im_wdata;
   logic            core_rst;
   logic            core_done;
   logic            run_done;
   logic            timeout;
   logic            len_err;
   logic [TO_W-1:0] run_cycles;

   modport master (
      output s_valid, s_data, core_done,
      input  s_ready, im_wr_en, im_addr, im_wdata, core_rst,
             run_done, timeout, len_err, run_cycles
   );

   modport slave (
      input  s_valid, s_data, core_done,
      output s_ready, im_wr_en, im_addr, im_wdata, core_rst,
             run_done, timeout, len_err, run_cycles
   );
endinterface

// File: rtl/imem_loader_run_timer.sv
// Saturating run-cycle counter: clear has priority, counts while enabled and
// stops at all-ones, which is flagged as the limit.
module run_timer import loader_pkg::*; #(
   parameter int TO_W = TO_W_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr_i,
   input  logic            en_i,
   output logic [TO_W-1:0] cnt_o,
   output logic            at_lim_o
);
   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;
   logic            at_lim_s;

   assign at_lim_s = &cnt_q;
   assign cnt_o    = cnt_q;
   assign at_lim_o = at_lim_s;

   // next count
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !at_lim_s) begin
         cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed program over a byte stream, writes 9-bit words to
// instruction memory, then releases the core and times its run.
module imem_loader import loader_pkg::*; #(
   parameter int D    = D_DEF,
   parameter int TO_W = TO_W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   imem_loader_if.slave   bus
);
   localparam logic [31:0] MAX_LEN = 32'd1 << D;

   state_t          state_q, state_d;
   logic [10:0]     len_q, len_d;
   logic [7:0]      lo_q, lo_d;
   logic [D-1:0]    idx_q, idx_d;
   logic            wr_en_q, wr_en_d;
   logic [D-1:0]    addr_q, addr_d;
   logic [8:0]      wdata_q, wdata_d;
   logic            core_rst_q, core_rst_d;
   logic            run_done_q, run_done_d;
   logic            timeout_q, timeout_d;
   logic            len_err_q, len_err_d;

   logic            ready_s;
   logic            accept_s;
   logic [10:0]     len_new_s;
   logic            len_bad_s;
   logic            last_s;
   logic            tmr_clr_s;
   logic            tmr_en_s;
   logic            at_lim_s;
   logic [TO_W-1:0] cnt_s;

   assign ready_s   = (state_q inside {LEN_LO, LEN_HI, INS_LO, INS_HI, DONE});
   assign accept_s  = bus.s_valid && ready_s;
   assign len_new_s = {bus.s_data[2:0], len_q[7:0]};
   assign len_bad_s = (len_new_s == 11'd0) || (32'(len_new_s) > MAX_LEN);
   assign last_s    = ((32'(idx_q) + 32'd1) == 32'(len_q));

   run_timer #(.TO_W(TO_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (tmr_clr_s),
      .en_i     (tmr_en_s),
      .cnt_o    (cnt_s),
      .at_lim_o (at_lim_s)
   );

   // next-state and datapath decode
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      lo_d       = lo_q;
      idx_d      = idx_q;
      wr_en_d    = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      run_done_d = run_done_q;
      timeout_d  = timeout_q;
      len_err_d  = len_err_q;
      tmr_clr_s  = 1'b0;
      tmr_en_s   = 1'b0;
      case (state_q)
         LEN_LO, DONE: begin
            if (accept_s) begin
               len_d      = {3'd0, bus.s_data};
               run_done_d = 1'b0;
               state_d    = LEN_HI;
            end else begin
               state_d = state_q;
            end
         end
         LEN_HI: begin
            if (accept_s) begin
               len_d = len_new_s;
               if (len_bad_s) begin
                  len_err_d = 1'b1;
                  state_d   = ERR;
               end else begin
                  idx_d   = '0;
                  state_d = INS_LO;
               end
            end else begin
               state_d = state_q;
            end
         end
         INS_LO: begin
            if (accept_s) begin
               lo_d    = bus.s_data;
               state_d = INS_HI;
            end else begin
               state_d = state_q;
            end
         end
         INS_HI: begin
            if (accept_s) begin
               wr_en_d = 1'b1;
               addr_d  = idx_q;
               wdata_d = {bus.s_data[0], lo_q};
               if (last_s) begin
                  tmr_clr_s = 1'b1;
                  state_d   = RUN;
               end else begin
                  idx_d   = idx_q + {{(D-1){1'b0}}, 1'b1};
                  state_d = INS_LO;
               end
            end else begin
               state_d = state_q;
            end
         end
         RUN: begin
            // core_done beats the counter limit when both land together
            if (bus.core_done) begin
               run_done_d = 1'b1;
               state_d    = DONE;
            end else if (at_lim_s) begin
               timeout_d = 1'b1;
               state_d   = ERR;
            end else begin
               tmr_en_s = 1'b1;
            end
         end
         ERR: begin
            state_d = ERR;
         end
         default: begin
            state_d = LEN_LO;
         end
      endcase
      // keep the core in reset through the last write strobe
      core_rst_d = (state_d != RUN) || wr_en_d;
   end

   // state and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= LEN_LO;
         len_q      <= 11'd0;
         lo_q       <= 8'd0;
         idx_q      <= '0;
         wr_en_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 9'd0;
         core_rst_q <= 1'b1;
         run_done_q <= 1'b0;
         timeout_q  <= 1'b0;
         len_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         lo_q       <= lo_d;
         idx_q      <= idx_d;
         wr_en_q    <= wr_en_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         core_rst_q <= core_rst_d;
         run_done_q <= run_done_d;
         timeout_q  <= timeout_d;
         len_err_q  <= len_err_d;
      end
   end

   assign bus.s_ready    = ready_s;
   assign bus.im_wr_en   = wr_en_q;
   assign bus.im_addr    = addr_q;
   assign bus.im_wdata   = wdata_q;
   assign bus.core_rst   = core_rst_q;
   assign bus.run_done   = run_done_q;
   assign bus.timeout    = timeout_q;
   assign bus.len_err    = len_err_q;
   assign bus.run_cycles = cnt_s;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a main instance (TO_W=16) and a short-timer
// instance (TO_W=4) share the stimulus through a select.
module tb_imem_loader;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0;
   logic       tb_valid = 1'b0;
   logic [7:0] tb_data = 8'd0;
   logic       tb_done = 1'b0;
   int         n_chk = 0;
   int         n_err = 0;
   int         wr_cnt = 0;
   logic       prev_wr = 1'b0;
   logic [31:0] sb_q[$];

   always #5 clk = ~clk;

   imem_loader_if #(.D(10), .TO_W(16)) bm ();
   imem_loader_if #(.D(10), .TO_W(4))  bt ();

   assign bm.s_valid   = tb_valid & ~sel;
   assign bt.s_valid   = tb_valid & sel;
   assign bm.s_data    = tb_data;
   assign bt.s_data    = tb_data;
   assign bm.core_done = tb_done & ~sel;
   assign bt.core_done = tb_done & sel;

   imem_loader #(.D(10), .TO_W(16)) dut   (.clk(clk), .reset(rst_n), .bus(bm));
   imem_loader #(.D(10), .TO_W(4))  dut_t (.clk(clk), .reset(rst_n), .bus(bt));

   logic        cur_ready, cur_wr, cur_crst, cur_rdone, cur_tout, cur_lerr;
   logic [31:0] cur_addr, cur_wdata, cur_rc;
   assign cur_ready = sel ? bt.s_ready  : bm.s_ready;
   assign cur_wr    = sel ? bt.im_wr_en : bm.im_wr_en;
   assign cur_crst  = sel ? bt.core_rst : bm.core_rst;
   assign cur_rdone = sel ? bt.run_done : bm.run_done;
   assign cur_tout  = sel ? bt.timeout  : bm.timeout;
   assign cur_lerr  = sel ? bt.len_err  : bm.len_err;
   assign cur_addr  = sel ? 32'(bt.im_addr)  : 32'(bm.im_addr);
   assign cur_wdata = sel ? 32'(bt.im_wdata) : 32'(bm.im_wdata);
   assign cur_rc    = sel ? 32'(bt.run_cycles) : 32'(bm.run_cycles);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // write monitor: pops the scoreboard on each strobe
   always @(negedge clk) begin
      if (rst_n && cur_wr) begin
         wr_cnt++;
         chk("wr_single_cycle", 32'(prev_wr), 32'd0);
         chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            logic [31:0] e;
            e = sb_q.pop_front();
            chk("wr_addr", cur_addr, {16'd0, e[31:16]});
            chk("wr_data", cur_wdata, {16'd0, e[15:0]});
         end
      end
      prev_wr = rst_n && cur_wr;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      tb_valid = 1'b1;
      tb_data  = b;
      while (!cur_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         chk("send_bound", 32'(n), 32'd0);
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
      tb_valid = 1'b0;
   endtask

   task automatic send_len(input int len);
      logic [7:0] b;
      b = 8'($urandom);
      b[2:0] = 3'(len >> 8);
      send_byte(8'(len));
      send_byte(b);
   endtask

   task automatic send_word(input int addr, input logic [8:0] w, input int stall);
      logic [7:0] hi;
      send_byte(w[7:0]);
      idle(stall);
      hi = 8'($urandom);
      hi[0] = w[8];
      sb_q.push_back({16'(addr), 7'd0, w});
      send_byte(hi);
      idle(stall);
   endtask

   task automatic chk_reset_vals();
      chk("rst_s_ready", 32'(cur_ready), 32'd1);
      chk("rst_core_rst", 32'(cur_crst), 32'd1);
      chk("rst_wr_en", 32'(cur_wr), 32'd0);
      chk("rst_addr", cur_addr, 32'd0);
      chk("rst_wdata", cur_wdata, 32'd0);
      chk("rst_run_done", 32'(cur_rdone), 32'd0);
      chk("rst_timeout", 32'(cur_tout), 32'd0);
      chk("rst_len_err", 32'(cur_lerr), 32'd0);
      chk("rst_run_cycles", cur_rc, 32'd0);
   endtask

   task automatic do_reset(input bit check);
      #2;
      rst_n    = 1'b0;
      tb_valid = 1'b0;
      tb_done  = 1'b0;
      #1;
      if (check) chk_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int w0;
      logic [8:0] w;
      logic [8:0] wlast;
      @(negedge clk);
      chk_reset_vals();
      rst_n = 1'b1;
      @(negedge clk);

      // reference program of three words
      send_byte(8'h03); send_byte(8'h00);
      sb_q.push_back({16'd0, 16'h01AA}); send_byte(8'hAA); send_byte(8'h01);
      sb_q.push_back({16'd1, 16'h0055}); send_byte(8'h55); send_byte(8'h00);
      sb_q.push_back({16'd2, 16'h010F}); send_byte(8'h0F); send_byte(8'h01);
      chk("core_rst_during_last_wr", 32'(cur_crst), 32'd1);
      @(negedge clk);
      chk("core_rst_released", 32'(cur_crst), 32'd0);
      chk("ref_wr_count", 32'(wr_cnt), 32'd3);
      idle(4);
      tb_done = 1'b1;
      @(negedge clk);
      tb_done = 1'b0;
      chk("ref_run_done", 32'(cur_rdone), 32'd1);
      chk("ref_run_cycles", cur_rc, 32'd5);

      // reload from DONE
      send_byte(8'h02);
      chk("done_reload_clears", 32'(cur_rdone), 32'd0);
      send_byte(8'hF8);
      send_word(0, 9'($urandom), 0);
      wlast = 9'($urandom);
      send_word(1, wlast, 0);
      chk("rerun_cleared", cur_rc, 32'd0);
      @(negedge clk);
      chk("rerun_count1", cur_rc, 32'd1);
      chk("addr_hold", cur_addr, 32'd1);
      chk("wdata_hold", cur_wdata, 32'(wlast));
      idle(2);
      tb_done = 1'b1;
      @(negedge clk);
      tb_done = 1'b0;

      // single word, core finishes 40 cycles into RUN
      send_len(1);
      send_word(0, 9'($urandom), 0);
      idle(40);
      tb_done = 1'b1;
      @(negedge clk);
      tb_done = 1'b0;
      chk("r40_run_done", 32'(cur_rdone), 32'd1);
      chk("r40_run_cycles", cur_rc, 32'd40);
      chk("r40_core_rst", 32'(cur_crst), 32'd1);
      tb_done = 1'b1;
      idle(2);
      tb_done = 1'b0;
      chk("done_ignored_cycles", cur_rc, 32'd40);
      chk("done_ignored_flag", 32'(cur_rdone), 32'd1);

      // illegal lengths
      do_reset(0);
      w0 = wr_cnt;
      send_byte(8'h00); send_byte(8'h00);
      chk("len0_err", 32'(cur_lerr), 32'd1);
      chk("len0_not_ready", 32'(cur_ready), 32'd0);
      tb_valid = 1'b1;
      idle(3);
      tb_valid = 1'b0;
      chk("err_sticky_ready", 32'(cur_ready), 32'd0);
      chk("err_sticky_lerr", 32'(cur_lerr), 32'd1);
      do_reset(0);
      send_byte(8'h01); send_byte(8'h04);
      chk("len1025_err", 32'(cur_lerr), 32'd1);
      chk("len_err_no_wr", 32'(wr_cnt), 32'(w0));
      do_reset(0);
      send_len(1024);
      chk("len1024_ok", 32'(cur_lerr), 32'd0);
      chk("len1024_ready", 32'(cur_ready), 32'd1);

      // stalled load of 5 words, aborted by reset inside word 2
      do_reset(0);
      send_len(5);
      idle(1);
      for (int i = 0; i < 2; i++) send_word(i, 9'($urandom), 1);
      w = 9'($urandom);
      send_byte(w[7:0]);
      idle(1);
      do_reset(1);
      chk("abort_sb_empty", 32'(sb_q.size()), 32'd0);
      send_len(2);
      for (int i = 0; i < 2; i++) send_word(i, 9'($urandom), 0);
      idle(1);
      chk("post_abort_sb_empty", 32'(sb_q.size()), 32'd0);

      // short-timer instance: timeout, then done/limit tie
      sel = 1'b1;
      do_reset(1);
      send_len(1);
      send_word(0, 9'($urandom), 0);
      idle(15);
      chk("to_before", 32'(cur_tout), 32'd0);
      chk("to_cycles15", cur_rc, 32'd15);
      @(negedge clk);
      chk("to_flag", 32'(cur_tout), 32'd1);
      chk("to_not_ready", 32'(cur_ready), 32'd0);
      chk("to_core_rst", 32'(cur_crst), 32'd1);
      chk("to_no_run_done", 32'(cur_rdone), 32'd0);
      do_reset(0);
      send_len(1);
      send_word(0, 9'($urandom), 0);
      idle(15);
      tb_done = 1'b1;
      @(negedge clk);
      tb_done = 1'b0;
      chk("tie_run_done", 32'(cur_rdone), 32'd1);
      chk("tie_no_timeout", 32'(cur_tout), 32'd0);
      chk("tie_cycles", cur_rc, 32'd15);

      chk("sb_empty_end", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
